// File: rtl/conv_pkg.sv
`default_nettype none
// ============================================================================
// conv_pkg: shared types and helpers for the 3x3 convolution engine.
// Optional feature macro: CONV_RELU_EN selects unsigned (ReLU) clamping.
// Revision: 1.0
// ============================================================================
package conv_pkg;

  localparam int ACC_BITS = 21;

  typedef logic [8:0][31:0] kernel_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } conv_state_t;

  // Returns the clamped value; the caller keeps the low 'bits' bits.
  function automatic int clamp_pix(input logic signed [ACC_BITS-1:0] v, input int bits);
    int sv;
    int hi;
    int lo;
    sv = int'(v);
`ifdef CONV_RELU_EN
    hi = (1 << bits) - 1;
    lo = 0;
`else
    hi = (1 << (bits - 1)) - 1;
    lo = -(1 << (bits - 1));
`endif
    if (sv > hi) return hi;
    if (sv < lo) return lo;
    return sv;
  endfunction

endpackage
`default_nettype wire

// File: rtl/conv_line_buffer.sv
`default_nettype none
// ============================================================================
// conv_line_buffer: two IMG_W-deep row delay lines with shift enable,
// presenting the three vertically aligned pixels of the current column.
// Revision: 1.0
// ============================================================================
module conv_line_buffer
  import conv_pkg::*;
#(
  parameter int IMG_W      = 8,
  parameter int PIXEL_SIZE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr,
  input  logic                  en,
  input  logic [PIXEL_SIZE-1:0] pix,
  output logic [PIXEL_SIZE-1:0] tap_top,
  output logic [PIXEL_SIZE-1:0] tap_mid,
  output logic [PIXEL_SIZE-1:0] tap_bot
);

  logic [PIXEL_SIZE-1:0] line1 [IMG_W];
  logic [PIXEL_SIZE-1:0] line2 [IMG_W];

  // Tail of each line holds the pixel of the same column one/two rows back.
  assign tap_bot = pix;
  assign tap_mid = line1[IMG_W-1];
  assign tap_top = line2[IMG_W-1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < IMG_W; i++) begin
        line1[i] <= '0;
        line2[i] <= '0;
      end
    end else if (clr) begin
      for (int i = 0; i < IMG_W; i++) begin
        line1[i] <= '0;
        line2[i] <= '0;
      end
    end else if (en) begin
      line1[0] <= pix;
      line2[0] <= line1[IMG_W-1];
      for (int i = 1; i < IMG_W; i++) begin
        line1[i] <= line1[i-1];
        line2[i] <= line2[i-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/conv3x3_engine.sv
`default_nettype none
// ============================================================================
// conv3x3_engine: streaming 3x3 valid-only convolution with a 3-stage MAC
// pipeline and requantising clamp. Macro CONV_RELU_EN: unsigned 0..255 output.
// Revision: 1.0
// ============================================================================
module conv3x3_engine
  import conv_pkg::*;
#(
  parameter int IMG_W      = 8,
  parameter int IMG_H      = 8,
  parameter int PIXEL_SIZE = 8,
  parameter int COEF_BITS  = 8,
  parameter int SHIFT      = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_kernel,
  input  logic [8:0][31:0]      kernel,
  input  logic                  start,
  input  logic [PIXEL_SIZE-1:0] pixel_in,
  input  logic                  pixel_in_valid,
  output logic [PIXEL_SIZE-1:0] pixel_out,
  output logic                  pixel_out_valid,
  output logic                  conv_done,
  output logic                  busy
);

  localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

  conv_state_t state;
  logic [CW-1:0] col;
  logic [RW-1:0] row;

  logic signed [COEF_BITS-1:0] coef [9];
  logic [PIXEL_SIZE-1:0]       win  [3][3];
  logic [PIXEL_SIZE-1:0]       tap  [3];
  logic                        win_valid;
  logic                        win_last;

  logic signed [ACC_BITS-1:0] prod_c [9];
  logic signed [ACC_BITS-1:0] prod   [9];
  logic signed [ACC_BITS-1:0] rsum_c [3];
  logic signed [ACC_BITS-1:0] rsum   [3];
  logic signed [ACC_BITS-1:0] total_c;
  logic                       v1, v2, l1, l2;

  logic accept;
  logic last_pix;

  // A start in the same cycle as a pixel takes priority; the pixel is dropped.
  assign accept   = (state == ST_RUN) && pixel_in_valid && !start;
  assign last_pix = (col == CW'(IMG_W - 1)) && (row == RW'(IMG_H - 1));

  conv_line_buffer #(
    .IMG_W      (IMG_W),
    .PIXEL_SIZE (PIXEL_SIZE)
  ) u_line_buffer (
    .clk     (clk),
    .reset   (reset),
    .clr     (start),
    .en      (accept),
    .pix     (pixel_in),
    .tap_top (tap[0]),
    .tap_mid (tap[1]),
    .tap_bot (tap[2])
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 9; k++) coef[k] <= '0;
    end else if (load_kernel) begin
      for (int k = 0; k < 9; k++) coef[k] <= COEF_BITS'(kernel[k]);
    end
  end

  // Control FSM, raster counters and the 3x3 window.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      col       <= '0;
      row       <= '0;
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      for (int r = 0; r < 3; r++)
        for (int c = 0; c < 3; c++) win[r][c] <= '0;
    end else begin
      win_valid <= 1'b0;
      win_last  <= 1'b0;
      if (start) begin
        state <= ST_RUN;
        busy  <= 1'b1;
        col   <= '0;
        row   <= '0;
      end else begin
        case (state)
          ST_IDLE: ;
          ST_RUN: begin
            if (accept) begin
              win_valid <= (row >= RW'(2)) && (col >= CW'(2));
              win_last  <= last_pix;
              if (col == CW'(IMG_W - 1)) begin
                col <= '0;
                row <= (row == RW'(IMG_H - 1)) ? '0 : row + 1'b1;
              end else begin
                col <= col + 1'b1;
              end
              if (last_pix) state <= ST_FLUSH;
            end
          end
          ST_FLUSH: begin
            if (conv_done) begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
      if (accept) begin
        for (int r = 0; r < 3; r++) begin
          win[r][0] <= win[r][1];
          win[r][1] <= win[r][2];
          win[r][2] <= tap[r];
        end
      end
    end
  end

  always_comb begin
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        prod_c[r*3+c] = $signed(ACC_BITS'({1'b0, win[r][c]})) * ACC_BITS'(coef[r*3+c]);
    for (int r = 0; r < 3; r++)
      rsum_c[r] = prod[r*3] + prod[r*3+1] + prod[r*3+2];
    total_c = rsum[0] + rsum[1] + rsum[2];
  end

  // MAC pipeline: products, row sums, total + shift + clamp.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 9; k++) prod[k] <= '0;
      for (int r = 0; r < 3; r++) rsum[r] <= '0;
      v1              <= 1'b0;
      v2              <= 1'b0;
      l1              <= 1'b0;
      l2              <= 1'b0;
      pixel_out       <= '0;
      pixel_out_valid <= 1'b0;
      conv_done       <= 1'b0;
    end else begin
      v1              <= win_valid && !start;
      l1              <= win_last && !start;
      v2              <= v1 && !start;
      l2              <= l1 && !start;
      pixel_out_valid <= v2 && !start;
      conv_done       <= v2 && l2 && !start;
      if (win_valid) begin
        for (int k = 0; k < 9; k++) prod[k] <= prod_c[k];
      end
      if (v1) begin
        for (int r = 0; r < 3; r++) rsum[r] <= rsum_c[r];
      end
      if (v2) pixel_out <= PIXEL_SIZE'(clamp_pix(total_c >>> SHIFT, PIXEL_SIZE));
    end
  end

endmodule
`default_nettype wire
